// File: rtl/decoder_nto2n_seq_if.sv
// Request/response bundle for the registered N-to-2^N decoder with scan sequencer.
interface decoder_nto2n_seq_if #(
  parameter int N       = 4,
  parameter int DWELL_W = 8
);
  localparam int NL = 1 << N;

  logic               en;
  logic               in_valid;
  logic               mode;
  logic [N-1:0]       a;
  logic [DWELL_W-1:0] dwell;

  logic [NL-1:0]      y;
  logic [N-1:0]       sel;
  logic               y_valid;
  logic               busy;
  logic               wrap;

  modport master (
    output en, in_valid, mode, a, dwell,
    input  y, sel, y_valid, busy, wrap
  );

  modport slave (
    input  en, in_valid, mode, a, dwell,
    output y, sel, y_valid, busy, wrap
  );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered one-hot decoder with a built-in scan sequencer.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | y holds the last direct/aborted decode (or zero); waits
// SCAN    | walks y across all lines, each held dwell_q+1 cycles
module decoder_nto2n_seq #(
  parameter int N       = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  decoder_nto2n_seq_if.slave bus
);
  localparam int NL = 1 << N;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NL-1:0]      y_q, y_d;
  logic [N-1:0]       sel_q, sel_d;
  logic               y_valid_q, y_valid_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  // Next-state: en low kills everything, a request overrides any scan step.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    sel_d     = sel_q;
    y_valid_d = 1'b0;
    wrap_d    = 1'b0;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;

    if (!bus.en) begin
      state_d = ST_IDLE;
      y_d     = '0;
    end else if (bus.in_valid) begin
      sel_d        = bus.a;
      y_d          = '0;
      y_d[bus.a]   = 1'b1;
      y_valid_d    = 1'b1;
      if (bus.mode) begin
        state_d = ST_SCAN;
        dwell_d = bus.dwell;
        cnt_d   = bus.dwell;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_SCAN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        // sel wraps naturally at N bits; flag the top-to-zero step
        sel_d        = sel_q + 1'b1;
        y_d          = '0;
        y_d[sel_d]   = 1'b1;
        y_valid_d    = 1'b1;
        wrap_d       = (sel_q == '1);
        cnt_d        = dwell_q;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      sel_q     <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      cnt_q     <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      sel_q     <= sel_d;
      y_valid_q <= y_valid_d;
      wrap_q    <= wrap_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.sel     = sel_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state_q == ST_SCAN);
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench for decoder_nto2n_seq (N=4, DWELL_W=8).
module tb_decoder_nto2n_seq;
  localparam int N       = 4;
  localparam int DWELL_W = 8;

  typedef struct packed {
    logic [15:0] y;
    logic [3:0]  sel;
    logic        y_valid;
    logic        busy;
    logic        wrap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   wraps;

  exp_t q_exp[$];

  // reference model state
  logic        m_scan;
  logic [15:0] m_y;
  logic [3:0]  m_sel;
  logic        m_yv;
  logic        m_wrap;
  logic [7:0]  m_cnt;
  logic [7:0]  m_dwell;

  decoder_nto2n_seq_if #(.N(N), .DWELL_W(DWELL_W)) bus ();

  decoder_nto2n_seq #(.N(N), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge given the inputs being presented.
  task automatic model_step(input logic r, input logic e, input logic iv, input logic md,
                            input logic [3:0] aa, input logic [7:0] dw);
    m_yv   = 1'b0;
    m_wrap = 1'b0;
    if (!r) begin
      m_scan = 1'b0; m_y = '0; m_sel = '0; m_cnt = '0; m_dwell = '0;
    end else if (!e) begin
      m_scan = 1'b0; m_y = '0;
    end else if (iv) begin
      m_sel = aa;
      m_y   = 16'h0001 << aa;
      m_yv  = 1'b1;
      m_scan = md;
      if (md) begin
        m_dwell = dw;
        m_cnt   = dw;
      end
    end else if (m_scan) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 8'd1;
      end else begin
        m_wrap = (m_sel == 4'd15);
        m_sel  = (m_sel == 4'd15) ? 4'd0 : m_sel + 4'd1;
        m_y    = 16'h0001 << m_sel;
        m_yv   = 1'b1;
        m_cnt  = m_dwell;
      end
    end
  endtask

  // Drive one cycle of stimulus, push expectation, then pop and compare.
  task automatic cycle(input logic r, input logic e, input logic iv, input logic md,
                       input logic [3:0] aa, input logic [7:0] dw);
    exp_t ex;
    exp_t nx;
    @(negedge clk);
    rst_n        = r;
    bus.en       = e;
    bus.in_valid = iv;
    bus.mode     = md;
    bus.a        = aa;
    bus.dwell    = dw;
    model_step(r, e, iv, md, aa, dw);
    nx.y = m_y; nx.sel = m_sel; nx.y_valid = m_yv; nx.busy = m_scan; nx.wrap = m_wrap;
    q_exp.push_back(nx);
    @(posedge clk);
    #1;
    ex = q_exp.pop_front();
    chk("y",       32'(bus.y),       32'(ex.y));
    chk("sel",     32'(bus.sel),     32'(ex.sel));
    chk("y_valid", 32'(bus.y_valid), 32'(ex.y_valid));
    chk("busy",    32'(bus.busy),    32'(ex.busy));
    chk("wrap",    32'(bus.wrap),    32'(ex.wrap));
    if (bus.wrap) wraps++;
  endtask

  initial begin
    checks = 0; failures = 0; wraps = 0;
    m_scan = 0; m_y = '0; m_sel = '0; m_yv = 0; m_wrap = 0; m_cnt = '0; m_dwell = '0;
    rst_n = 1'b0; bus.en = 1'b1; bus.in_valid = 1'b1; bus.mode = 1'b1;
    bus.a = 4'd7; bus.dwell = 8'd3;

    // reset held with a pending request
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 8'd3);
    chk("rst_y", 32'(bus.y), 32'h0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    // direct sweep, then hold
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'(i), 8'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 8'd9);
    chk("direct_hold", 32'(bus.y), 32'h8000);

    // scan from 14 with dwell 2; dwell wiggles between requests must not matter
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 8'd2);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)));

    // abort to direct 5
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 8'd0);
    chk("abort_y", 32'(bus.y), 32'h0020);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    // dwell 0 scan from 0: two full sweeps
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0);
    wraps = 0;
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    chk("wrap_count", 32'(wraps), 32'd2);

    // restart at 9 with 2-cycle hold
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 8'd1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    // kill with simultaneous request, then re-enable without request
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 8'd0);
    chk("kill_y", 32'(bus.y), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    chk("reenable_y", 32'(bus.y), 32'h0);

    // random traffic including occasional reset and en drops
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 40) != 0), 1'($urandom_range(0, 15) != 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
